// File: rtl/float_div_pipeline_pkg.sv
// Shared single-precision float constants, the divider state encoding and a field view of a float word.
package float_div_pipeline_pkg;

  localparam int FLOAT_WIDTH      = 32;
  localparam int FLOAT_EXP_WIDTH  = 8;
  localparam int FLOAT_MANT_WIDTH = 23;
  localparam int FLOAT_BIAS       = 127;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2
  } state_e;

  typedef struct packed {
    logic                        sign;
    logic [FLOAT_EXP_WIDTH-1:0]  exp;
    logic [FLOAT_MANT_WIDTH-1:0] mant;
  } float_t;

endpackage

// File: rtl/float_div_step.sv
// One restoring-division step: subtract the divisor when it fits, emit the quotient bit, shift the remainder.
module float_div_step
  import float_div_pipeline_pkg::*;
#(
  parameter int MANT_W = FLOAT_MANT_WIDTH
) (
  input  logic [MANT_W+1:0] rem,
  input  logic [MANT_W:0]   mb,
  output logic [MANT_W+1:0] next_rem,
  output logic              q_bit
);

  logic [MANT_W+1:0] mb_ext;
  logic [MANT_W+1:0] diff;

  always_comb begin
    mb_ext   = {1'b0, mb};
    q_bit    = (rem >= mb_ext);
    diff     = q_bit ? (rem - mb_ext) : rem;
    next_rem = diff << 1;
  end

endmodule

// File: rtl/float_div_pipeline.sv
// Multi-cycle float divider: req sampled in IDLE, 25 restoring steps, one normalise cycle, one-cycle ack.
// Zero/denormal operands are flushed and answered on the sampling edge; result is truncated and saturated.
module float_div_pipeline
  import float_div_pipeline_pkg::*;
#(
  parameter int float_width      = FLOAT_WIDTH,
  parameter int float_exp_width  = FLOAT_EXP_WIDTH,
  parameter int float_mant_width = FLOAT_MANT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic                   ack,
  output logic [float_width-1:0] out
);

  localparam int MW    = float_mant_width;
  localparam int EW    = float_exp_width;
  localparam int SEW   = EW + 2;
  localparam int STEPS = MW + 2;
  localparam int CW    = $clog2(STEPS);
  localparam logic signed [SEW-1:0] EXP_SAT  = SEW'((1 << EW) - 1);
  localparam logic signed [SEW-1:0] EXP_ONE  = SEW'(1);
  localparam logic signed [SEW-1:0] EXP_ZERO = '0;

  state_e                 state_q, state_d;
  logic [MW:0]            ma, mb_q, mb_d;
  logic [MW+1:0]          rem_q, rem_d, q_q, q_d, step_rem;
  logic                   step_bit;
  logic signed [SEW-1:0]  exp_q, exp_d, exp_n;
  logic                   sign_q, sign_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ack_d;
  logic [float_width-1:0] out_d;
  logic [MW-1:0]          mant_n;
  logic [EW-1:0]          a_exp, b_exp;

  assign a_exp = a[MW +: EW];
  assign b_exp = b[MW +: EW];

  float_div_step #(.MANT_W(MW)) u_step (
    .rem      (rem_q),
    .mb       (mb_q),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  always_comb begin
    state_d = state_q;
    mb_d    = mb_q;
    rem_d   = rem_q;
    q_d     = q_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    out_d   = '0;
    ma      = {1'b1, a[MW-1:0]};
    exp_n   = exp_q;
    mant_n  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          // Zero dividend takes priority over zero divisor, so 0/0 yields +0.
          if (a_exp == '0) begin
            ack_d = 1'b1;
          end else if (b_exp == '0) begin
            ack_d = 1'b1;
            out_d = {a[float_width-1] ^ b[float_width-1], {EW{1'b1}}, {MW{1'b0}}};
          end else begin
            mb_d    = {1'b1, b[MW-1:0]};
            rem_d   = {1'b0, ma};
            q_d     = '0;
            sign_d  = a[float_width-1] ^ b[float_width-1];
            exp_d   = SEW'(a_exp) - SEW'(b_exp) + SEW'(FLOAT_BIAS);
            cnt_d   = '0;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        q_d   = {q_q[MW:0], step_bit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = ST_NORM;
      end
      ST_NORM: begin
        if (q_q[MW+1]) begin
          mant_n = q_q[MW:1];
        end else begin
          mant_n = q_q[MW-1:0];
          exp_n  = exp_q - EXP_ONE;
        end
        if (exp_n >= EXP_SAT)       out_d = {sign_q, {EW{1'b1}}, {MW{1'b0}}};
        else if (exp_n <= EXP_ZERO) out_d = '0;
        else                        out_d = {sign_q, exp_n[EW-1:0], mant_n};
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mb_q    <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      ack     <= 1'b0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      mb_q    <= mb_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      ack     <= ack_d;
      out     <= out_d;
    end
  end

endmodule

// File: tb/tb_float_div_pipeline.sv
// Bench for float_div_pipeline: vector table plus abort and back-to-back sequences, checked through a scoreboard.
module tb_float_div_pipeline;
  import float_div_pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic [31:0] a, b;
  logic        ack;
  logic [31:0] q_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_count = 0;
  int idle_bad = 0;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    int          id;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  float_div_pipeline dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .a   (a),
    .b   (b),
    .ack (ack),
    .out (q_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Independent reference: integer long division of the significands.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    float_t fx, fy;
    longint mx, my, q;
    int e;
    logic s;
    logic [22:0] m;
    fx = x;
    fy = y;
    if (fx.exp == 0) return 32'h0;
    s = fx.sign ^ fy.sign;
    if (fy.exp == 0) return {s, 8'hFF, 23'h0};
    mx = longint'({1'b1, fx.mant});
    my = longint'({1'b1, fy.mant});
    q  = (mx << 24) / my;
    e  = int'(fx.exp) - int'(fy.exp) + 127;
    if (q >= (longint'(1) << 24)) m = q[23:1];
    else begin
      m = q[22:0];
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return 32'h0;
    return {s, e[7:0], m};
  endfunction

  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
    if (x[30:23] == 8'h0 || y[30:23] == 8'h0) return 0;
    return 26;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (ack) begin
        ack_count++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: cycle %0d out=%08h, required no ack", cyc, q_out);
        end else begin
          sb_t e;
          e = sb.pop_front();
          checks++;
          if (q_out !== e.val) begin
            errors++;
            $display("FAIL result[%0d]: out=%08h, required %08h", e.id, q_out, e.val);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency[%0d]: ack at cycle %0d, required cycle %0d", e.id, cyc, e.cyc);
          end
        end
      end else if (q_out !== 32'h0) begin
        idle_bad++;
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Drive one request at a negedge; the following posedge is the sampling edge.
  task automatic run_one(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat, input int id);
    sb_t s;
    a   = x;
    b   = y;
    req = 1'b1;
    s.val = e;
    s.cyc = cyc + 1 + lat;
    s.id  = id;
    sb.push_back(s);
    @(negedge clk);
    req = 1'b0;
    wait_drain(40);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, req_v);
    end
  endtask

  vec_t vecs[12];

  initial begin
    int base, acks_before;
    sb_t s;
    logic [31:0] ops_a[3], ops_b[3];

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 26};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26};
    vecs[2]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 26};
    vecs[3]  = '{32'h00000000, 32'h40A00000, 32'h00000000, 0};
    vecs[4]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 0};
    vecs[5]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 26};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 26};
    vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 0};
    vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h00000000, 0};
    vecs[9]  = '{32'h40000000, 32'h3F000000, 32'h40800000, 26};
    vecs[10] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 26};
    vecs[11] = '{32'h00800000, 32'h3FC00000, 32'h00000000, 26};

    rst = 1'b1;
    req = 1'b0;
    a   = '0;
    b   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_ack", {31'h0, ack}, 32'h0);
    check_eq("reset_out", q_out, 32'h0);

    foreach (vecs[i]) run_one(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] x, y;
      x = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 200)), 23'($urandom)};
      y = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 200)), 23'($urandom)};
      run_one(x, y, ref_div(x, y), ref_lat(x, y), 100 + i);
    end

    // Abort on the 10th DIV cycle, and reset colliding with a request.
    acks_before = ack_count;
    a   = 32'h40C00000;
    b   = 32'h40000000;
    req = 1'b1;
    base = cyc;
    @(negedge clk);
    req = 1'b0;
    wait_cyc(base + 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_out", q_out, 32'h0);
    req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("abort_no_ack", ack_count, acks_before);
    run_one(32'h41200000, 32'h40A00000, 32'h40000000, 26, 200);

    // Three back-to-back operations with req held; a/b scrambled during DIV.
    ops_a[0] = 32'h40C00000; ops_b[0] = 32'h40000000;
    ops_a[1] = 32'h3F800000; ops_b[1] = 32'h40400000;
    ops_a[2] = 32'hC1200000; ops_b[2] = 32'h40A00000;
    base = cyc;
    for (int k = 0; k < 3; k++) begin
      wait_cyc(base + 27 * k);
      a   = ops_a[k];
      b   = ops_b[k];
      req = 1'b1;
      s.val = ref_div(ops_a[k], ops_b[k]);
      s.cyc = base + 27 * k + 1 + 26;
      s.id  = 300 + k;
      sb.push_back(s);
      wait_cyc(base + 27 * k + 5);
      a = 32'h3F800000 ^ {k[7:0], 24'h5A5A5A};
      b = 32'h00000000;
    end
    wait_cyc(base + 27 * 2 + 2);
    req = 1'b0;
    wait_drain(60);
    check_eq("idle_out_zero", idle_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_div_pipeline.md
FLOAT_DIV_PIPELINE -- requirements
Module: float_div_pipeline

Interface
REQ-001 SHALL expose parameters float_width (32, total bits), float_exp_width (8, exponent bits) and float_mant_width (23, stored mantissa bits), taken from the shared package.
REQ-002 SHALL have clk: input, 1 bit, the single clock; all state changes on posedge.
REQ-003 SHALL have rst: input, 1 bit, synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have req: input, 1 bit, start request; flop-driven by the initiator.
REQ-005 SHALL have ack: output reg, 1 bit, result-valid pulse.
REQ-006 SHALL have a: input, float_width bits, dividend.
REQ-007 SHALL have b: input, float_width bits, divisor.
REQ-008 SHALL have out: output reg, float_width bits, the quotient a/b.

Function
REQ-009 SHALL implement states IDLE, DIV and NORM.
REQ-010 SHALL sample req, a and b only in IDLE; req in DIV or NORM is ignored.
REQ-011 SHALL, when a.exp==0 (zero/denormal, flushed), register out=0x00000000 and ack=1 on the sampling edge and stay in IDLE; this check has priority, so 0/0 gives +0.
REQ-012 SHALL, when a.exp!=0 and b.exp==0, register out={a.sign^b.sign, all-ones exp, zero mant} (signed infinity) and ack=1 on the sampling edge and stay in IDLE.
REQ-013 SHALL otherwise latch ma={1,a.mant} and mb={1,b.mant} (float_mant_width+1 bits each), sign=a.sign^b.sign and signed exp=a.exp-b.exp+127 (float_exp_width+2 bits), clear the quotient, set rem=ma, clear the step counter and go to DIV.
REQ-014 SHALL perform one restoring step per DIV cycle:
- if rem>=mb, set quotient bit 1 and rem-=mb, else set quotient bit 0;
- then rem<<=1;
- quotient bits are filled MSB first, from bit float_mant_width+1 down to bit 0.
REQ-015 SHALL run exactly float_mant_width+2 (25) DIV cycles, then enter NORM; rem SHALL be float_mant_width+2 bits wide.
REQ-016 SHALL in NORM normalise the quotient:
- if q[float_mant_width+1]==1, use mant=q[float_mant_width:1] and the exponent unchanged;
- else use mant=q[float_mant_width-1:0] and the exponent minus 1.
REQ-017 SHALL round by truncation (the remainder is discarded).
REQ-018 SHALL saturate the final exponent: >=255 gives signed infinity; <=0 gives +0.
REQ-019 SHALL register the result and ack=1 in NORM, then return to IDLE.
REQ-020 SHALL have latency: for normal operands ack is high in the cycle after the 26th posedge following the sampling edge; for the special cases of REQ-011/012 ack is high in the cycle after the sampling edge.
REQ-021 SHALL hold ack high for exactly one cycle; out SHALL be 0 whenever ack is 0.
REQ-022 SHALL accept a new req in the IDLE cycle that coincides with ack; a req held continuously therefore restarts immediately.
REQ-023 SHALL treat inputs with exp all-ones (inf/NaN) as ordinary finite numbers; these are not a supported use.

Reset
REQ-024 SHALL, on rst, set state=IDLE, ack=0, out=0, and clear all internal registers (ma, mb, rem, quotient, exponent, sign, counter).
REQ-025 SHALL let rst win over a simultaneous req.
REQ-026 SHALL ensure that rst in DIV or NORM aborts the operation and that no ack is produced for the aborted operation.

Structure
REQ-027 SHALL take float_width, float_exp_width, float_mant_width and the exponent bias 127 from the shared float package, not from local constants.
REQ-028 SHALL keep the state enum in the same package as the float constants.
REQ-029 SHALL implement the REQ-014 step as the combinational sub-module float_div_step, with inputs rem and mb and outputs next_rem and q_bit.
REQ-030 SHALL use one combinational next-state block plus one clocked register block.

Verification
REQ-031 SHALL check 0x40C00000 / 0x40000000 (6.0/2.0) -> out=0x40400000, with ack exactly 26 edges after the sampling edge and for one cycle only.
REQ-032 SHALL check 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated); and 0xBF800000 / 0x3F800000 -> 0xBF800000.
REQ-033 SHALL check 0x00000000 / 0x40A00000 -> 0x00000000, and 0xBF800000 / 0x00000000 -> 0xFF800000, each with ack one cycle after sampling.
REQ-034 SHALL check overflow and underflow: 0x7F000000 / 0x00800000 -> 0x7F800000; 0x00800000 / 0x40000000 -> 0x00000000.
REQ-035 SHALL check that rst asserted on the 10th DIV cycle gives no ack, then 0x41200000 / 0x40A00000 (10/5) -> 0x40000000 normally.
REQ-036 SHALL check that req held high over 3 operations with changing a/b gives 3 acks spaced 27 cycles apart, each with the correct result, and that a/b changes during DIV do not affect the result.
